// File: rtl/reorder_buffer_if.sv
// Issue, result-broadcast, operand-query, commit and flush signals of the reorder buffer.
// Latency: none (wiring only); the master side is issue/CDB/register file, the slave side is the ROB.
// Backpressure: issue is refused while fullOut is high; no other path can be stalled.
interface reorder_buffer_if #(parameter int ROB_WIDTH = 4);
  // issue side
  logic                 issueValid;
  logic                 issueHasRd;
  logic [4:0]           issueRd;
  logic                 issueIsBranch;
  logic                 issuePredTaken;
  logic [31:0]          issueAltPc;
  logic [ROB_WIDTH-1:0] issueId;
  logic                 fullOut;
  // result broadcast
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbId;
  logic [31:0]          cdbValue;
  logic                 cdbTaken;
`ifdef ROB_DUAL_CDB_EN
  logic                 cdb2Valid;
  logic [ROB_WIDTH-1:0] cdb2Id;
  logic [31:0]          cdb2Value;
  logic                 cdb2Taken;
`endif
  // operand lookups
  logic [ROB_WIDTH-1:0] query1Id;
  logic                 query1Ready;
  logic [31:0]          query1Value;
  logic [ROB_WIDTH-1:0] query2Id;
  logic                 query2Ready;
  logic [31:0]          query2Value;
  // commit and flush
  logic                 writeFlag;
  logic [ROB_WIDTH-1:0] robId;
  logic [4:0]           writeAddr;
  logic [31:0]          writeValue;
  logic                 clearOut;
  logic [31:0]          clearPc;

  modport master (
    output issueValid, issueHasRd, issueRd, issueIsBranch, issuePredTaken, issueAltPc,
    output cdbValid, cdbId, cdbValue, cdbTaken,
`ifdef ROB_DUAL_CDB_EN
    output cdb2Valid, cdb2Id, cdb2Value, cdb2Taken,
`endif
    output query1Id, query2Id,
    input  issueId, fullOut, query1Ready, query1Value, query2Ready, query2Value,
    input  writeFlag, robId, writeAddr, writeValue, clearOut, clearPc
  );

  modport slave (
    input  issueValid, issueHasRd, issueRd, issueIsBranch, issuePredTaken, issueAltPc,
    input  cdbValid, cdbId, cdbValue, cdbTaken,
`ifdef ROB_DUAL_CDB_EN
    input  cdb2Valid, cdb2Id, cdb2Value, cdb2Taken,
`endif
    input  query1Id, query2Id,
    output issueId, fullOut, query1Ready, query1Value, query2Ready, query2Value,
    output writeFlag, robId, writeAddr, writeValue, clearOut, clearPc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, collects CDB results, retires one entry per cycle.
// Latency: CDB result to head -> writeFlag two cycles later; issueId/fullOut/queries are combinational.
// Backpressure: issue ignored while full; readyIn=0 freezes all state and registered outputs.
// Optional second result bus via macro ROB_DUAL_CDB_EN (port 1 wins on a same-id collision).
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic clockIn,
  input  logic resetIn,
  input  logic readyIn,
  reorder_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_COUNT = (ROB_WIDTH+1)'(DEPTH);
  localparam logic [ROB_WIDTH:0]   COUNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH-1:0] PTR_ONE    = ROB_WIDTH'(1);

  logic [DEPTH-1:0]     busy, ready, hasRd, isBranch, predTaken, taken;
  logic [4:0]           rdMem    [DEPTH];
  logic [31:0]          valueMem [DEPTH];
  logic [31:0]          altPcMem [DEPTH];
  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;

  logic full, issueEn, cdbEn, commitEn, mispredict;
`ifdef ROB_DUAL_CDB_EN
  logic cdb2En;
  assign cdb2En = readyIn & bus.cdb2Valid & busy[bus.cdb2Id];
`endif

  assign full       = (count == FULL_COUNT);
  assign issueEn    = readyIn & bus.issueValid & ~full;
  assign cdbEn      = readyIn & bus.cdbValid & busy[bus.cdbId];
  assign commitEn   = readyIn & busy[head] & ready[head];
  // a wrong prediction is only acted on when the branch reaches the head
  assign mispredict = commitEn & isBranch[head] & (taken[head] != predTaken[head]);

  assign bus.issueId = tail;
  assign bus.fullOut = full;

  // operand lookup: live CDB data takes priority over stored entry state
  function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] id);
    logic [32:0] r;
    r = {busy[id] & ready[id], valueMem[id]};
`ifdef ROB_DUAL_CDB_EN
    if (bus.cdb2Valid && bus.cdb2Id == id) r = {1'b1, bus.cdb2Value};
`endif
    if (bus.cdbValid && bus.cdbId == id) r = {1'b1, bus.cdbValue};
    return r;
  endfunction

  assign {bus.query1Ready, bus.query1Value} = lookup(bus.query1Id);
  assign {bus.query2Ready, bus.query2Value} = lookup(bus.query2Id);

  // entry state, pointers and registered commit/flush outputs
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      bus.writeFlag  <= 1'b0;
      bus.robId      <= '0;
      bus.writeAddr  <= '0;
      bus.writeValue <= '0;
      bus.clearOut   <= 1'b0;
      bus.clearPc    <= '0;
    end else if (readyIn) begin
      if (mispredict) begin
        // flush everything; same-cycle issue and CDB traffic is dropped
        bus.clearOut  <= 1'b1;
        bus.clearPc   <= altPcMem[head];
        bus.writeFlag <= 1'b0;
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        busy          <= '0;
      end else begin
        bus.clearOut  <= 1'b0;
        bus.writeFlag <= commitEn & hasRd[head] & (rdMem[head] != 5'd0);
        if (commitEn) begin
          bus.robId      <= head;
          bus.writeAddr  <= rdMem[head];
          bus.writeValue <= valueMem[head];
          busy[head]     <= 1'b0;
          head           <= head + PTR_ONE;
        end
`ifdef ROB_DUAL_CDB_EN
        // port 2 first so that port 1 overrides it on a shared id
        if (cdb2En) begin
          valueMem[bus.cdb2Id] <= bus.cdb2Value;
          taken[bus.cdb2Id]    <= bus.cdb2Taken;
          ready[bus.cdb2Id]    <= 1'b1;
        end
`endif
        if (cdbEn) begin
          valueMem[bus.cdbId] <= bus.cdbValue;
          taken[bus.cdbId]    <= bus.cdbTaken;
          ready[bus.cdbId]    <= 1'b1;
        end
        // tail is never busy when not full, so CDB cannot collide with this write
        if (issueEn) begin
          busy[tail]      <= 1'b1;
          ready[tail]     <= 1'b0;
          hasRd[tail]     <= bus.issueHasRd;
          rdMem[tail]     <= bus.issueRd;
          isBranch[tail]  <= bus.issueIsBranch;
          predTaken[tail] <= bus.issuePredTaken;
          altPcMem[tail]  <= bus.issueAltPc;
          tail            <= tail + PTR_ONE;
        end
        case ({issueEn, commitEn})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
// Expected commits are queued at issue time; values are recorded when a CDB result is driven.
// Every comparison goes through chk(), which counts and reports mismatches.
module tb_reorder_buffer;
  logic clockIn = 1'b0;
  logic resetIn = 1'b0;
  logic readyIn = 1'b1;
  always #5 clockIn = ~clockIn;

  reorder_buffer_if #(.ROB_WIDTH(4)) bus();
  reorder_buffer #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .readyIn(readyIn),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [4:0] rd;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] expVal [16];
  logic [3:0]  mTail = 4'd0;
  logic [3:0]  lastId;
  logic [4:0]  lastAddr;
  logic [31:0] lastVal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic hasRd, input logic isBr,
                       input logic pred, input logic [31:0] alt);
    bus.issueValid     = 1'b1;
    bus.issueRd        = rd;
    bus.issueHasRd     = hasRd;
    bus.issueIsBranch  = isBr;
    bus.issuePredTaken = pred;
    bus.issueAltPc     = alt;
    #1;
    chk("issueId", 32'(bus.issueId), 32'(mTail));
    if (hasRd && rd != 5'd0) sb.push_back(exp_t'{mTail, rd});
    tick();
    bus.issueValid = 1'b0;
    mTail++;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [31:0] val, input logic tk);
    bus.cdbValid = 1'b1;
    bus.cdbId    = id;
    bus.cdbValue = val;
    bus.cdbTaken = tk;
    expVal[id]   = val;
    tick();
    bus.cdbValid = 1'b0;
  endtask

  task automatic expectCommit(input string tag);
    exp_t e;
    chk({tag, ".flag"}, 32'(bus.writeFlag), 32'd1);
    chk({tag, ".sbEmpty"}, 32'(sb.size() == 0), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".robId"}, 32'(bus.robId), 32'(e.id));
      chk({tag, ".addr"}, 32'(bus.writeAddr), 32'(e.rd));
      chk({tag, ".value"}, bus.writeValue, expVal[e.id]);
      lastId   = e.id;
      lastAddr = e.rd;
      lastVal  = expVal[e.id];
    end
  endtask

  initial begin
    bus.issueValid = 1'b0; bus.issueHasRd = 1'b0; bus.issueRd = '0;
    bus.issueIsBranch = 1'b0; bus.issuePredTaken = 1'b0; bus.issueAltPc = '0;
    bus.cdbValid = 1'b0; bus.cdbId = '0; bus.cdbValue = '0; bus.cdbTaken = 1'b0;
    bus.query1Id = '0; bus.query2Id = '0;
`ifdef ROB_DUAL_CDB_EN
    bus.cdb2Valid = 1'b0; bus.cdb2Id = '0; bus.cdb2Value = '0; bus.cdb2Taken = 1'b0;
`endif
    for (int i = 0; i < 16; i++) expVal[i] = '0;

    // reset state
    resetIn = 1'b0;
    tick(); tick();
    chk("rst.writeFlag", 32'(bus.writeFlag), 32'd0);
    chk("rst.clearOut", 32'(bus.clearOut), 32'd0);
    chk("rst.fullOut", 32'(bus.fullOut), 32'd0);
    chk("rst.issueId", 32'(bus.issueId), 32'd0);
    chk("rst.robId", 32'(bus.robId), 32'd0);
    chk("rst.writeValue", bus.writeValue, 32'd0);
    chk("rst.clearPc", bus.clearPc, 32'd0);
    resetIn = 1'b1;

    // in-order commit, two-cycle CDB-to-writeFlag latency
    issue(5'd5, 1'b1, 1'b0, 1'b0, 32'd0);
    issue(5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.query1Id = 4'd1;
    cdb(4'd0, 32'h11, 1'b0);
    chk("t1.early", 32'(bus.writeFlag), 32'd0);
    tick();
    expectCommit("t1.c0");
    tick();
    chk("t1.id1wait", 32'(bus.writeFlag), 32'd0);
    chk("t1.q1notReady", 32'(bus.query1Ready), 32'd0);

    // out-of-order results still retire in order
    issue(5'd7, 1'b1, 1'b0, 1'b0, 32'd0);
    cdb(4'd2, 32'h22, 1'b0);
    chk("t2.noCommit", 32'(bus.writeFlag), 32'd0);
    cdb(4'd1, 32'h11, 1'b0);
    chk("t2.early", 32'(bus.writeFlag), 32'd0);
    tick();
    expectCommit("t2.c1");
    tick();
    expectCommit("t2.c2");
    tick();
    chk("t2.idle", 32'(bus.writeFlag), 32'd0);

    // query bypass, then a commit to rd=0
    issue(5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.query1Id = 4'd3; bus.query2Id = 4'd4;
    bus.cdbValid = 1'b1; bus.cdbId = 4'd3; bus.cdbValue = 32'hABCD; bus.cdbTaken = 1'b0;
    #1;
    chk("t3.bypassReady", 32'(bus.query1Ready), 32'd1);
    chk("t3.bypassValue", bus.query1Value, 32'hABCD);
    chk("t3.q2idle", 32'(bus.query2Ready), 32'd0);
    tick();
    bus.cdbValid = 1'b0;
    #1;
    chk("t3.storedReady", 32'(bus.query1Ready), 32'd1);
    chk("t3.storedValue", bus.query1Value, 32'hABCD);
    tick();
    chk("t3.rd0Flag", 32'(bus.writeFlag), 32'd0);
    chk("t3.rd0RobId", 32'(bus.robId), 32'd3);
    chk("t3.retired", 32'(bus.query1Ready), 32'd0);

    // mispredicted branch at head with younger busy entries
    issue(5'd0, 1'b0, 1'b1, 1'b0, 32'h100);
    issue(5'd9, 1'b1, 1'b0, 1'b0, 32'd0);
    issue(5'd10, 1'b1, 1'b0, 1'b0, 32'd0);
    cdb(4'd5, 32'h55, 1'b0);
    cdb(4'd4, 32'h0, 1'b1);
    bus.issueValid = 1'b1; bus.issueRd = 5'd11; bus.issueHasRd = 1'b1; bus.issueIsBranch = 1'b0;
    bus.cdbValid = 1'b1; bus.cdbId = 4'd6; bus.cdbValue = 32'h66;
    tick();
    bus.issueValid = 1'b0; bus.cdbValid = 1'b0;
    sb.delete();
    mTail = 4'd0;
    bus.query1Id = 4'd5; bus.query2Id = 4'd6;
    #1;
    chk("t4.clearOut", 32'(bus.clearOut), 32'd1);
    chk("t4.clearPc", bus.clearPc, 32'h100);
    chk("t4.writeFlag", 32'(bus.writeFlag), 32'd0);
    chk("t4.issueId", 32'(bus.issueId), 32'd0);
    chk("t4.fullOut", 32'(bus.fullOut), 32'd0);
    chk("t4.q5flushed", 32'(bus.query1Ready), 32'd0);
    chk("t4.q6flushed", 32'(bus.query2Ready), 32'd0);
    tick();
    chk("t4.clearPulse", 32'(bus.clearOut), 32'd0);

    // fill to 16, refuse the 17th, commit one, wrap tail
    for (int i = 0; i < 16; i++) begin
      chk("t5.notFull", 32'(bus.fullOut), 32'd0);
      issue(5'(i + 1), 1'b1, 1'b0, 1'b0, 32'd0);
    end
    chk("t5.full", 32'(bus.fullOut), 32'd1);
    bus.issueValid = 1'b1; bus.issueRd = 5'd30;
    tick();
    bus.issueValid = 1'b0;
    chk("t5.tailHeld", 32'(bus.issueId), 32'd0);
    chk("t5.stillFull", 32'(bus.fullOut), 32'd1);
    cdb(4'd0, 32'h44, 1'b0);
    chk("t5.fullBeforeCommit", 32'(bus.fullOut), 32'd1);
    bus.issueValid = 1'b1; bus.issueRd = 5'd29;
    tick();
    bus.issueValid = 1'b0;
    expectCommit("t5.c0");
    chk("t5.afterCommit", 32'(bus.fullOut), 32'd0);
    chk("t5.issueIgnored", 32'(bus.issueId), 32'd0);
    issue(5'd17, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t5.refull", 32'(bus.fullOut), 32'd1);

    // readyIn low freezes a pending CDB and a pending commit
    cdb(4'd1, 32'h77, 1'b0);
    cdb(4'd2, 32'h88, 1'b0);
    expectCommit("t6.c1");
    readyIn = 1'b0;
    bus.cdbValid = 1'b1; bus.cdbId = 4'd3; bus.cdbValue = 32'h99;
    expVal[3] = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.holdFlag", 32'(bus.writeFlag), 32'd1);
      chk("t6.holdRobId", 32'(bus.robId), 32'(lastId));
      chk("t6.holdAddr", 32'(bus.writeAddr), 32'(lastAddr));
      chk("t6.holdValue", bus.writeValue, lastVal);
      chk("t6.holdCount", 32'(bus.fullOut), 32'd0);
    end
    bus.cdbValid = 1'b0;
    bus.query1Id = 4'd3;
    #1;
    chk("t6.cdbBlocked", 32'(bus.query1Ready), 32'd0);
    readyIn = 1'b1;
    tick();
    expectCommit("t6.c2");

    // reset mid-stream wins over readyIn=0
    readyIn = 1'b0;
    resetIn = 1'b0;
    tick();
    chk("t7.writeFlag", 32'(bus.writeFlag), 32'd0);
    chk("t7.clearOut", 32'(bus.clearOut), 32'd0);
    chk("t7.robId", 32'(bus.robId), 32'd0);
    chk("t7.writeAddr", 32'(bus.writeAddr), 32'd0);
    chk("t7.writeValue", bus.writeValue, 32'd0);
    chk("t7.fullOut", 32'(bus.fullOut), 32'd0);
    chk("t7.issueId", 32'(bus.issueId), 32'd0);
    chk("t7.q3", 32'(bus.query1Ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
